// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: round-robin grant on ties, fixed three-state
// access sequence (IDLE -> ACCESS -> DONE) with latched request attributes.
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ready,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ready,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t        state_r, state_s;
  logic          last_r, last_s;
  logic          owner_r, owner_s;
  logic          we_r, we_s;
  logic [AW-1:0] addr_r, addr_s;
  logic [DW-1:0] wdata_r, wdata_s;
  logic          grant_s;
  logic          done_s;

  // Next-state, grant selection and attribute capture
  always_comb begin
    state_s = state_r;
    last_s  = last_r;
    owner_s = owner_r;
    we_s    = we_r;
    addr_s  = addr_r;
    wdata_s = wdata_r;
    grant_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (m0_req || m1_req) begin
          // On a tie the requester that did not win last time goes next
          if (m0_req && m1_req) begin
            grant_s = ~last_r;
          end else if (m1_req) begin
            grant_s = 1'b1;
          end else begin
            grant_s = 1'b0;
          end
          state_s = ACCESS;
          last_s  = grant_s;
          owner_s = grant_s;
          if (grant_s) begin
            we_s    = m1_we;
            addr_s  = m1_addr;
            wdata_s = m1_wdata;
          end else begin
            we_s    = m0_we;
            addr_s  = m0_addr;
            wdata_s = m0_wdata;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS:  state_s = DONE;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State and latched-attribute registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      last_r  <= 1'b1;
      owner_r <= 1'b0;
      we_r    <= 1'b0;
      addr_r  <= {AW{1'b0}};
      wdata_r <= {DW{1'b0}};
    end else begin
      state_r <= state_s;
      last_r  <= last_s;
      owner_r <= owner_s;
      we_r    <= we_s;
      addr_r  <= addr_s;
      wdata_r <= wdata_s;
    end
  end

  // Outputs decode directly from registered state, so they are glitch-free
  assign done_s    = (state_r == DONE);
  assign mem_en    = (state_r == ACCESS);
  assign mem_we    = mem_en & we_r;
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;
  assign busy      = (state_r != IDLE);
  assign owner     = owner_r;
  assign m0_ready  = done_s & ~owner_r;
  assign m1_ready  = done_s & owner_r;
  assign m0_rdata  = (m0_ready && !we_r) ? mem_rdata : {DW{1'b0}};
  assign m1_rdata  = (m1_ready && !we_r) ? mem_rdata : {DW{1'b0}};

endmodule
